// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state encoding, 4x4 matrix geometry and key-code width shared by the scanner files.
package keypad_pkg;
   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int CODE_W = 4;
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
   // Rows are active-low; the lowest-index low row wins when several are pressed.
   function automatic logic [1:0] first_low(input logic [ROWS-1:0] r);
      return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
   endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the asynchronous row inputs, idles high (no key).
module keypad_sync
   import keypad_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] d,
   output logic [ROWS-1:0] q
);
   logic [ROWS-1:0] meta;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, meta} <= '1;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with debounce and a valid/ready key output.
// Define KEYPAD_REPEAT_EN to re-issue a held key after REPEAT_DELAY, then every REPEAT_RATE samples.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_RATE    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   row_in,
   output logic [COLS-1:0]   col_out,
   input  logic              key_ready,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_lost
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(DEBOUNCE_SCANS);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_SCANS - 1);

   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("keypad_scanner: parameter out of range");
   end

   state_t          state;
   logic [1:0]      col, row, low_row;
   logic [DW-1:0]   dwell;
   logic [BW-1:0]   cnt;
   logic [ROWS-1:0] row_s;
   logic            tick, low_any, same, rep_hit, accept, fire;

   keypad_sync u_sync (.clk(clk), .rst(rst), .d(row_in), .q(row_s));

   assign col_out = ~(4'b0001 << col);

   always_comb begin
      tick    = dwell == DIV_LAST;
      low_any = row_s != 4'hF;
      low_row = first_low(row_s);
      same    = low_any && low_row == row;
      fire    = key_valid && key_ready;
      accept  = tick && ((state == DEBOUNCE && same && cnt == DEB_LAST) || rep_hit);
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
   logic [RW-1:0] rep_cnt;
   logic          rep_phase;
   // First repeat waits the long delay; rep_phase switches to the short rate afterwards.
   assign rep_hit = state == HELD && low_any && rep_cnt == (rep_phase ? RATE_LAST : DELAY_LAST);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (state != HELD) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (tick && low_any) begin
         rep_cnt   <= rep_hit ? '0 : rep_cnt + 1'b1;
         rep_phase <= rep_phase | rep_hit;
      end
`else
   assign rep_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= SCAN;
         col       <= '0;
         row       <= '0;
         dwell     <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_lost  <= 1'b0;
      end else begin
         dwell <= tick ? '0 : dwell + 1'b1;
         if (tick)
            case (state)
               SCAN:
                  if (low_any) begin
                     row   <= low_row;
                     cnt   <= BW'(1);
                     state <= DEBOUNCE;
                  end else col <= col + 1'b1;
               DEBOUNCE:
                  if (!same) begin
                     state <= SCAN;
                     col   <= col + 1'b1;
                  end else if (cnt == DEB_LAST) begin
                     state <= HELD;
                     cnt   <= '0;
                  end else cnt <= cnt + 1'b1;
               HELD:
                  if (low_any) cnt <= '0;
                  else if (cnt == DEB_LAST) begin
                     state <= SCAN;
                     col   <= col + 1'b1;
                     cnt   <= '0;
                  end else cnt <= cnt + 1'b1;
               default: state <= SCAN;
            endcase
         // A key is only dropped when the previous one is still waiting and not being taken now.
         if (accept && (!key_valid || key_ready)) begin
            key_code  <= {row, col};
            key_valid <= 1'b1;
         end else if (fire) key_valid <= 1'b0;
         if (accept && key_valid && !key_ready) key_lost <= 1'b1;
         else if (fire && !accept) key_lost <= 1'b0;
      end
endmodule
